// File: rtl/ws2812_pkg.sv
// Shared types and colour-wheel helper for the ws2812 pattern generators.
package ws2812_pkg;

   localparam int RGB_W     = 24;
   localparam int LED_IDX_W = 8;

   // Field order matches the WS2812 wire order, so the struct packs straight into rgb_data.
   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } rgb_t;

   // Three-segment colour wheel; every product and difference stays within 8 bits.
   function automatic rgb_t wheel(input logic [7:0] h);
      rgb_t       c;
      logic [7:0] q;
      c = '0;
      q = '0;
      if (h < 8'd85) begin
         c.r = 8'd255 - h * 8'd3;
         c.g = h * 8'd3;
      end else if (h < 8'd170) begin
         q   = h - 8'd85;
         c.g = 8'd255 - q * 8'd3;
         c.b = q * 8'd3;
      end else begin
         q   = h - 8'd170;
         c.r = q * 8'd3;
         c.b = 8'd255 - q * 8'd3;
      end
      return c;
   endfunction

endpackage

// File: rtl/ws2812_frame_timer.sv
// Free-running frame timer: counts 0..FRAME_DIV-1 while enabled, held at 0 otherwise.
module ws2812_frame_timer #(
   parameter int FRAME_DIV = 12000000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int                 TIMER_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [TIMER_W-1:0] LAST    = TIMER_W'(FRAME_DIV - 1);

   logic [TIMER_W-1:0] timer_q;
   logic [TIMER_W-1:0] timer_d;
   logic               at_last;

   always_comb begin
      at_last = (timer_q == LAST);
      timer_d = timer_q;
      if (!enable || at_last) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TIMER_W'(1);
      end
   end

   assign tick = enable && at_last;

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/ws2812_rainbow_gen.sv
// Rotating rainbow source: once per frame writes one wheel colour per LED, then advances the hue.
module ws2812_rainbow_gen
   import ws2812_pkg::*;
#(
   parameter int         NUM_LEDS     = 4,
   parameter int         FRAME_DIV    = 12000000,
   parameter logic [7:0] HUE_STEP     = 8'd64,
   parameter int         BRIGHT_SHIFT = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   output logic [LED_IDX_W-1:0] led_num,
   output logic [RGB_W-1:0]     rgb_data,
   output logic                 write,
   output logic                 frame_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [LED_IDX_W-1:0] LAST_IDX = LED_IDX_W'(NUM_LEDS - 1);

   logic                 tick;
   logic [1:0]           state_q, state_d;
   logic [LED_IDX_W-1:0] idx_q, idx_d;
   logic [7:0]           offset_q, offset_d;
   rgb_t                 rgb_q, rgb_d;
   logic                 write_q, write_d;
   logic                 frame_done_q, frame_done_d;
   logic [7:0]           hue;
   rgb_t                 wheel_c;

   ws2812_frame_timer #(
      .FRAME_DIV (FRAME_DIV)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   // Outputs are registered from next-state values, so write rises the cycle after tick.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      idx_d        = idx_q;
      offset_d     = offset_q;
      write_d      = 1'b0;
      frame_done_d = 1'b0;
      rgb_d        = rgb_q;
      hue          = '0;
      wheel_c      = '0;

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_WRITE;
               idx_d   = '0;
               write_d = 1'b1;
            end
         end
         ST_WRITE: begin
            if (idx_q == LAST_IDX) begin
               state_d      = ST_DONE;
               frame_done_d = 1'b1;
               offset_d     = offset_q + 8'd1;
            end else begin
               idx_d   = idx_q + LED_IDX_W'(1);
               write_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      hue     = offset_q + idx_d * HUE_STEP;
      wheel_c = wheel(hue);
      if (write_d) begin
         rgb_d.g = wheel_c.g >> BRIGHT_SHIFT;
         rgb_d.r = wheel_c.r >> BRIGHT_SHIFT;
         rgb_d.b = wheel_c.b >> BRIGHT_SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         offset_q     <= '0;
         rgb_q        <= '0;
         write_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         offset_q     <= offset_d;
         rgb_q        <= rgb_d;
         write_q      <= write_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign led_num    = idx_q;
   assign rgb_data   = rgb_q;
   assign write      = write_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/ws2812_rainbow_gen.md
Name: ws2812_rainbow_gen

Overview:
- Upstream pattern source for the ws2812 LED driver. Generates a rotating rainbow ("colour wheel chase") across the LED string.
- Once per frame it writes one 24-bit colour per LED into the driver's LED register file using the driver's rgb_data / led_num / write interface.
- After each frame it advances a hue offset, so the rainbow moves along the string.

Parameters:
- NUM_LEDS, 4, number of LEDs to write per frame; 1..255; must equal the driver's NUM_LEDS.
- FRAME_DIV, 12000000, clk cycles per frame; must be >= NUM_LEDS+2.
- HUE_STEP, 8'd64, hue increment between adjacent LEDs (mod 256).
- BRIGHT_SHIFT, 0, right-shift applied to every colour channel; 0..7.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run frame timer; low holds timer at 0
- led_num  out  8  LED index for the current write
- rgb_data  out  24  colour {green[7:0], red[7:0], blue[7:0]} (WS2812 wire order, MSB first)
- write  out  1  one-cycle strobe; driver latches led_num/rgb_data when high
- frame_done  out  1  one-cycle pulse after the last LED write of a frame

Behaviour:
- Reset (synchronous, reset high at a clk edge):
  - Outputs: led_num=0, rgb_data=0, write=0, frame_done=0.
  - Internal: timer=0, hue offset=0, LED index=0, state=IDLE.
  - Reset takes priority over everything else. Asserting reset mid-frame aborts the frame: write is low from the next edge, and the remaining LEDs are not written.
- Frame timer:
  - Counts 0..FRAME_DIV-1 and wraps while enable=1. When enable=0 it is held at 0.
  - tick = enable && timer==FRAME_DIV-1.
  - The timer keeps running during a frame.
- State machine, IDLE -> WRITE -> DONE -> IDLE:
  - IDLE: write=0. On tick, load idx=0 and go to WRITE.
  - WRITE: each cycle, write=1, led_num=idx, rgb_data=colour(idx). When idx==NUM_LEDS-1, go to DONE; otherwise idx++.
  - DONE: write=0, frame_done=1 for one cycle, offset <= offset+1 (8-bit wrap, 255->0), then go to IDLE.
  - A tick arriving in WRITE or DONE is ignored. This cannot happen when FRAME_DIV >= NUM_LEDS+2.
  - Deasserting enable mid-frame does not abort the frame; the frame completes normally.
- Timing: if tick occurs in cycle T, write is high in cycles T+1..T+NUM_LEDS (back-to-back, led_num 0,1,..) and frame_done is high in cycle T+NUM_LEDS+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Colour computation:
  - Hue: h = (offset + idx*HUE_STEP) mod 256, computed in 8 bits.
  - wheel(h):
    - h<85: r=255-3h, g=3h, b=0.
    - 85<=h<170, with q=h-85: r=0, g=255-3q, b=3q.
    - h>=170, with q=h-170: r=3q, g=0, b=255-3q.
  - All intermediate values fit in 8 bits; no saturation is needed.
  - Each channel is then shifted right by BRIGHT_SHIFT (logical shift).

Decomposition:
- Shared package ws2812_pkg:
  - RGB_W=24 and LED_IDX_W=8 constants.
  - rgb_t packed struct {g,r,b}.
  - Pure function wheel(h) returning rgb_t.
- Sub-module: ws2812_frame_timer (counter, enable hold, tick output). It is reusable by other pattern generators.
- The FSM and colour path stay in ws2812_rainbow_gen.

Test Plan (NUM_LEDS=4, FRAME_DIV=16, HUE_STEP=64, BRIGHT_SHIFT=0 unless stated):
- Reset: hold reset 5 cycles with enable=1 -> all outputs 0 during reset and until the first tick; the first tick occurs 16 cycles after reset release.
- Frame 0 -> exactly 4 consecutive write cycles:
  - led_num 0..3.
  - rgb_data 24'h00FF00, 24'hC03F00, 24'h7E0081, 24'h0042BD.
  - Then frame_done for 1 cycle, then write=0 until the next tick.
- Frame 1 -> led0 rgb_data=24'h03FC00 (offset 1). Run 256 further frames -> offset wraps and led0 returns to 24'h00FF00 on frame 256.
- BRIGHT_SHIFT=4 -> frame 0 led0 rgb_data=24'h000F00 and led1 rgb_data=24'h0C0300.
- Enable / abort cases:
  - enable=0 for 100 cycles -> no write and no frame_done.
  - Drop enable during the WRITE state -> the frame still completes with all 4 writes.
  - Assert reset in the cycle of the second write -> no further writes, and the next frame after release starts at offset 0.
- Bench hookup: connect to the ws2812 driver (NUM_LEDS=4) -> the driver's led_reg[1] holds 24'hC03F00 after frame 0.
